// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, scoreboard allocation and busy count.
// The master side (dispatch/writeback) drives requests; the slave side (the register file) answers.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] raddr_i;
  logic [NUM_RD*DATA_W-1:0] rdata_o;
  logic [NUM_RD-1:0]        rbusy_o;
  logic [NUM_WR-1:0]        wen_i;
  logic [NUM_WR*ADDR_W-1:0] waddr_i;
  logic [NUM_WR*DATA_W-1:0] wdata_i;
  logic                     alloc_vld_i;
  logic [ADDR_W-1:0]        alloc_addr_i;
  logic [ADDR_W:0]          busy_cnt_o;

  modport master (
    output raddr_i, wen_i, waddr_i, wdata_i, alloc_vld_i, alloc_addr_i,
    input  rdata_o, rbusy_o, busy_cnt_o
  );

  modport slave (
    input  raddr_i, wen_i, waddr_i, wdata_i, alloc_vld_i, alloc_addr_i,
    output rdata_o, rbusy_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and a pending-write
// scoreboard (busy bit per register plus a registered busy count).
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  regfile_mp_if.slave bus
);
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int CNT_MAX = (ZERO_R0 != 0) ? DEPTH - 1 : DEPTH;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_d;
  logic [ADDR_W:0]          busy_cnt_q;
  logic [ADDR_W:0]          busy_cnt_d;
  logic [NUM_WR-1:0]        wr_ok_s;
  logic                     alloc_ok_s;
  logic [NUM_RD*DATA_W-1:0] rdata_s;
  logic [NUM_RD-1:0]        rbusy_s;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  // Qualify writes and allocs: register 0 is hardwired when ZERO_R0 is set.
  always_comb begin
    wr_ok_s = {NUM_WR{1'b0}};
    for (int p = 0; p < NUM_WR; p++) begin
      wr_ok_s[p] = bus.wen_i[p] && !is_r0(bus.waddr_i[p*ADDR_W +: ADDR_W]);
    end
    alloc_ok_s = bus.alloc_vld_i && !is_r0(bus.alloc_addr_i);
  end

  // Next storage and busy state; later write ports override earlier ones, alloc overrides writes.
  always_comb begin
    logic [ADDR_W-1:0] wa;
    mem_d  = mem_q;
    busy_d = busy_q;
    wa     = {ADDR_W{1'b0}};
    for (int p = 0; p < NUM_WR; p++) begin
      wa         = bus.waddr_i[p*ADDR_W +: ADDR_W];
      mem_d[wa]  = wr_ok_s[p] ? bus.wdata_i[p*DATA_W +: DATA_W] : mem_d[wa];
      busy_d[wa] = wr_ok_s[p] ? 1'b0 : busy_d[wa];
    end
    busy_d[bus.alloc_addr_i] = alloc_ok_s ? 1'b1 : busy_d[bus.alloc_addr_i];
  end

  // Incremental busy count: each distinct set bit cleared counts once, unless re-allocated.
  always_comb begin
    logic [ADDR_W-1:0] wa;
    logic              dup_v;
    int                dec_v;
    int                cnt_v;
    wa    = {ADDR_W{1'b0}};
    dup_v = 1'b0;
    dec_v = 0;
    for (int p = 0; p < NUM_WR; p++) begin
      wa    = bus.waddr_i[p*ADDR_W +: ADDR_W];
      dup_v = 1'b0;
      for (int q = 0; q < p; q++) begin
        dup_v = dup_v || (wr_ok_s[q] && (bus.waddr_i[q*ADDR_W +: ADDR_W] == wa));
      end
      if (wr_ok_s[p] && busy_q[wa] && !dup_v && !(alloc_ok_s && (bus.alloc_addr_i == wa))) begin
        dec_v = dec_v + 1;
      end else begin
        dec_v = dec_v;
      end
    end
    cnt_v = int'(busy_cnt_q) - dec_v;
    if (alloc_ok_s && !busy_q[bus.alloc_addr_i]) begin
      cnt_v = cnt_v + 1;
    end else begin
      cnt_v = cnt_v;
    end
    if (cnt_v < 0) begin
      cnt_v = 0;
    end else if (cnt_v > CNT_MAX) begin
      cnt_v = CNT_MAX;
    end else begin
      cnt_v = cnt_v;
    end
    busy_cnt_d = cnt_v[ADDR_W:0];
  end

  // Read ports: stored value, optionally overridden by the highest matching write this cycle.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    rdata_s = {(NUM_RD*DATA_W){1'b0}};
    rbusy_s = {NUM_RD{1'b0}};
    ra      = {ADDR_W{1'b0}};
    val     = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      ra  = bus.raddr_i[k*ADDR_W +: ADDR_W];
      val = mem_q[ra];
      for (int p = 0; p < NUM_WR; p++) begin
        val = ((BYPASS != 0) && rst_n_i && bus.wen_i[p] &&
               (bus.waddr_i[p*ADDR_W +: ADDR_W] == ra)) ? bus.wdata_i[p*DATA_W +: DATA_W] : val;
      end
      rdata_s[k*DATA_W +: DATA_W] = is_r0(ra) ? {DATA_W{1'b0}} : val;
      rbusy_s[k]                  = busy_q[ra];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      busy_q     <= {DEPTH{1'b0}};
      busy_cnt_q <= {(ADDR_W+1){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.rdata_o    = rdata_s;
  assign bus.rbusy_o    = rbusy_s;
  assign bus.busy_cnt_o = busy_cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus
// and are checked every cycle against an architectural model, plus hand-computed literals.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        alloc_vld;
  logic [4:0]  alloc_addr;

  int vecs = 0;
  int bad  = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if_b ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if_n ();

  assign if_b.raddr_i = raddr;      assign if_n.raddr_i = raddr;
  assign if_b.wen_i = wen;          assign if_n.wen_i = wen;
  assign if_b.waddr_i = waddr;      assign if_n.waddr_i = waddr;
  assign if_b.wdata_i = wdata;      assign if_n.wdata_i = wdata;
  assign if_b.alloc_vld_i = alloc_vld;   assign if_n.alloc_vld_i = alloc_vld;
  assign if_b.alloc_addr_i = alloc_addr; assign if_n.alloc_addr_i = alloc_addr;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_R0(1))
    u_byp (.clk_i(clk), .rst_n_i(rst_n), .bus(if_b));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_R0(1))
    u_nob (.clk_i(clk), .rst_n_i(rst_n), .bus(if_n));

  always #5 clk = ~clk;

  // Architectural state: writes in port order, then alloc; r0 never written or busy.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
      m_busy <= 32'h0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wen[p] && waddr[p*5 +: 5] != 5'd0) begin
          m_mem[waddr[p*5 +: 5]]  <= wdata[p*32 +: 32];
          m_busy[waddr[p*5 +: 5]] <= 1'b0;
        end
      end
      if (alloc_vld && alloc_addr != 5'd0) m_busy[alloc_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = m_mem[a];
    if (byp && rst_n) begin
      for (int p = 0; p < 2; p++)
        if (wen[p] && waddr[p*5 +: 5] == a) v = wdata[p*32 +: 32];
    end
    return v;
  endfunction

  task automatic cmp(input string name, input int unit, input int port,
                     input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d port%0d got %h expected %h", name, unit, port, got, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      cmp("model_rdata", 1, k, if_b.rdata_o[k*32 +: 32], exp_rdata(raddr[k*5 +: 5], 1'b1));
      cmp("model_rdata", 0, k, if_n.rdata_o[k*32 +: 32], exp_rdata(raddr[k*5 +: 5], 1'b0));
      cmp("model_rbusy", 1, k, 32'(if_b.rbusy_o[k]), 32'(m_busy[raddr[k*5 +: 5]]));
      cmp("model_rbusy", 0, k, 32'(if_n.rbusy_o[k]), 32'(m_busy[raddr[k*5 +: 5]]));
    end
    cmp("model_cnt", 1, 0, 32'(if_b.busy_cnt_o), 32'($countones(m_busy)));
    cmp("model_cnt", 0, 0, 32'(if_n.busy_cnt_o), 32'($countones(m_busy)));
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 2'b00; waddr = 10'h0; wdata = 64'h0; alloc_vld = 1'b0; alloc_addr = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0; raddr = 10'h0; idle();
    advance(); advance();
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      sample();
      cmp("rst_rdata", 1, 0, if_b.rdata_o[31:0], 32'h0);
      cmp("rst_rbusy", 1, 1, 32'(if_b.rbusy_o), 32'h0);
      cmp("rst_cnt", 0, 0, 32'(if_n.busy_cnt_o), 32'h0);
      advance();
    end

    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF}; raddr = {5'd5, 5'd0};
    sample();
    cmp("r5_bypass", 1, 1, if_b.rdata_o[63:32], 32'hDEADBEEF);
    cmp("r5_nobypass", 0, 1, if_n.rdata_o[63:32], 32'h0);
    advance(); idle();
    sample();
    cmp("r5_stored", 0, 1, if_n.rdata_o[63:32], 32'hDEADBEEF);
    advance();

    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd0, 5'd7};
    sample();
    cmp("r7_bypass_prio", 1, 0, if_b.rdata_o[31:0], 32'h22);
    advance(); idle();
    sample();
    cmp("r7_stored_prio", 0, 0, if_n.rdata_o[31:0], 32'h22);
    advance();

    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h55}; raddr = 10'h0;
    sample();
    cmp("r0_bypass", 1, 0, if_b.rdata_o[31:0], 32'h0);
    advance(); idle();
    sample();
    cmp("r0_stored", 0, 0, if_n.rdata_o[31:0], 32'h0);
    advance();

    alloc_vld = 1'b1; alloc_addr = 5'd3; raddr = {5'd9, 5'd3};
    sample(); advance();
    alloc_addr = 5'd9;
    sample();
    cmp("alloc_r3_cnt", 1, 0, 32'(if_b.busy_cnt_o), 32'd1);
    cmp("alloc_r3_busy", 1, 0, 32'(if_b.rbusy_o), 32'b01);
    advance(); idle();
    sample();
    cmp("alloc_r9_cnt", 1, 0, 32'(if_b.busy_cnt_o), 32'd2);
    cmp("alloc_r9_busy", 0, 0, 32'(if_n.rbusy_o), 32'b11);
    advance();

    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33};
    sample();
    cmp("wr_r3_no_busy_fwd", 1, 0, 32'(if_b.rbusy_o), 32'b11);
    advance(); idle();
    sample();
    cmp("wr_r3_cnt", 1, 0, 32'(if_b.busy_cnt_o), 32'd1);
    cmp("wr_r3_busy", 1, 0, 32'(if_b.rbusy_o), 32'b10);
    advance();

    alloc_vld = 1'b1; alloc_addr = 5'd9; wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h99, 32'h0};
    sample(); advance(); idle();
    sample();
    cmp("alloc_wr_r9_cnt", 1, 0, 32'(if_b.busy_cnt_o), 32'd1);
    cmp("alloc_wr_r9_busy", 0, 1, 32'(if_n.rbusy_o[1]), 32'd1);
    cmp("alloc_wr_r9_data", 0, 1, if_n.rdata_o[63:32], 32'h99);
    advance();

    alloc_vld = 1'b1; alloc_addr = 5'd0; raddr = {5'd9, 5'd0};
    sample(); advance(); idle();
    sample();
    cmp("alloc_r0_cnt", 1, 0, 32'(if_b.busy_cnt_o), 32'd1);
    cmp("alloc_r0_busy", 1, 0, 32'(if_b.rbusy_o[0]), 32'd0);
    advance();

    for (int a = 1; a < 32; a++) begin
      alloc_vld = 1'b1; alloc_addr = 5'(a);
      sample(); advance();
    end
    idle();
    sample();
    cmp("alloc_all_cnt", 1, 0, 32'(if_b.busy_cnt_o), 32'd31);
    advance();

    rst_n = 1'b0; wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h1}; raddr = {5'd9, 5'd4};
    sample();
    cmp("rst_gates_bypass", 1, 0, if_b.rdata_o[31:0], 32'h0);
    advance(); rst_n = 1'b1; idle();
    sample();
    cmp("rst_mid_cnt", 1, 0, 32'(if_b.busy_cnt_o), 32'd0);
    cmp("rst_mid_r4", 1, 0, if_b.rdata_o[31:0], 32'h0);
    cmp("rst_mid_busy", 0, 1, 32'(if_n.rbusy_o), 32'd0);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
